// File: rtl/screen_scanout.sv
// screen_scanout
//   Snapshots a flat 24-bit-per-pixel frame once per frame. It then streams the
//   pixels in raster order over a valid/ready handshake, with line and frame
//   markers. Each line is followed by an idle gap, and each frame by a longer
//   one. Updates to `screen` that arrive mid-frame never reach the stream.
//
// Ports
//   clk        system clock
//   reset      asynchronous reset, active low
//   enable     allows a new frame to start (sampled in IDLE / end of VBLANK)
//   screen     flat frame, pixel p=y*SCR_W+x at [24p+23:24p], R/G/B = [23:16]/[15:8]/[7:0]
//   pix_ready  downstream accepts the presented pixel
//   pix_valid  pixel data valid
//   pix_rgb    pixel colour
//   pix_x      column of the presented pixel
//   pix_y      line of the presented pixel
//   line_end   presented pixel is the last of its line
//   frame_end  presented pixel is the last of the frame
//   busy       any state other than IDLE
//   frame_sum  per-frame R+G+B checksum (mod 2^16), 0 when the checksum is not built
//
// Build option
//   SCAN_CHECKSUM_EN  builds the frame_sum accumulator. Without it, frame_sum is tied to 0.
//
// SCR_W and SCR_H must be >= 2.

module screen_scanout #(
    parameter int SCR_W   = 30,
    parameter int SCR_H   = 30,
    parameter int BLANK_H = 4,
    parameter int BLANK_V = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [24*SCR_W*SCR_H-1:0]     screen,
    input  logic                          pix_ready,
    output logic                          pix_valid,
    output logic [23:0]                   pix_rgb,
    output logic [$clog2(SCR_W)-1:0]      pix_x,
    output logic [$clog2(SCR_H)-1:0]      pix_y,
    output logic                          line_end,
    output logic                          frame_end,
    output logic                          busy,
    output logic [15:0]                   frame_sum
);

    localparam int NPIX = SCR_W * SCR_H;
    localparam int XW   = $clog2(SCR_W);
    localparam int YW   = $clog2(SCR_H);
    localparam int PW   = $clog2(NPIX);
    localparam int BMAX = (BLANK_H > BLANK_V) ? BLANK_H : BLANK_V;
    localparam int BW   = (BMAX > 0) ? $clog2(BMAX + 1) : 1;

    // Blank counters count down to 0, so the load value is the length minus one.
    localparam logic [BW-1:0] H_LOAD = BW'((BLANK_H > 0) ? BLANK_H - 1 : 0);
    localparam logic [BW-1:0] V_LOAD = BW'((BLANK_V > 0) ? BLANK_V - 1 : 0);
    localparam logic [XW-1:0] X_LAST = XW'(SCR_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCR_H - 1);

    typedef enum logic [2:0] {IDLE, CAPTURE, ACTIVE, HBLANK, VBLANK} state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [BW-1:0]   blk_q, blk_d;
    logic [23:0]     snap_q [NPIX];
    logic [PW-1:0]   pix_idx;
    logic [23:0]     pix_rgb_d;
    logic            pix_valid_q, line_end_q, frame_end_q, busy_q;
    logic [23:0]     pix_rgb_q;
    logic            xfer;

    assign xfer = pix_valid_q & pix_ready;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        blk_d   = blk_q;
        case (state_q)
            IDLE:    if (enable) state_d = CAPTURE;
            CAPTURE: begin
                state_d = ACTIVE;
                x_d     = '0;
                y_d     = '0;
            end
            ACTIVE: if (xfer) begin
                if (x_q != X_LAST) begin
                    x_d = x_q + 1'b1;
                end else if (y_q != Y_LAST) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                    if (BLANK_H > 0) begin
                        state_d = HBLANK;
                        blk_d   = H_LOAD;
                    end
                end else begin
                    x_d = '0;
                    y_d = '0;
                    if (BLANK_V > 0) begin
                        state_d = VBLANK;
                        blk_d   = V_LOAD;
                    end else begin
                        state_d = enable ? CAPTURE : IDLE;
                    end
                end
            end
            HBLANK: begin
                if (blk_q == '0) state_d = ACTIVE;
                else             blk_d   = blk_q - 1'b1;
            end
            VBLANK: begin
                if (blk_q == '0) state_d = enable ? CAPTURE : IDLE;
                else             blk_d   = blk_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // The next pixel is looked up from the next x/y so that every pixel output is a flop.
    // During CAPTURE the snapshot is still being written, so pixel (0,0) comes straight from screen.
    always_comb begin
        pix_idx   = PW'(int'(y_d) * SCR_W + int'(x_d));
        pix_rgb_d = (state_q == CAPTURE) ? screen[23:0] : snap_q[pix_idx];
        if (state_d != ACTIVE) pix_rgb_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            blk_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_rgb_q   <= '0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NPIX; i++) snap_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            blk_q       <= blk_d;
            pix_valid_q <= (state_d == ACTIVE);
            pix_rgb_q   <= pix_rgb_d;
            line_end_q  <= (state_d == ACTIVE) && (x_d == X_LAST);
            frame_end_q <= (state_d == ACTIVE) && (x_d == X_LAST) && (y_d == Y_LAST);
            busy_q      <= (state_d != IDLE);
            if (state_q == CAPTURE)
                for (int i = 0; i < NPIX; i++) snap_q[i] <= screen[24*i +: 24];
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_rgb   = pix_rgb_q;
    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign line_end  = line_end_q;
    assign frame_end = frame_end_q;
    assign busy      = busy_q;

`ifdef SCAN_CHECKSUM_EN
    logic [15:0] acc_q, sum_q, px_sum;

    assign px_sum = 16'(pix_rgb_q[23:16]) + 16'(pix_rgb_q[15:8]) + 16'(pix_rgb_q[7:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            if (state_q == CAPTURE) acc_q <= '0;
            else if (xfer)          acc_q <= acc_q + px_sum;
            // The last pixel is folded in directly, so the published sum is complete on that edge.
            if (xfer && frame_end_q) sum_q <= acc_q + px_sum;
        end
    end

    assign frame_sum = sum_q;
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_screen_scanout.sv
module tb_screen_scanout;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int BH = 2;
    localparam int BV = 3;
    localparam int NP = W * H;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic [24*NP-1:0]      screen;
    logic                  pix_ready;
    logic                  pix_valid;
    logic [23:0]           pix_rgb;
    logic [1:0]            pix_x;
    logic [1:0]            pix_y;
    logic                  line_end;
    logic                  frame_end;
    logic                  busy;
    logic [15:0]           frame_sum;

    logic [23:0]           exp_pix [NP];
    int                    n_tests = 0;
    int                    n_fail  = 0;

    screen_scanout #(.SCR_W(W), .SCR_H(H), .BLANK_H(BH), .BLANK_V(BV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .screen(screen),
        .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .pix_x(pix_x), .pix_y(pix_y), .line_end(line_end), .frame_end(frame_end),
        .busy(busy), .frame_sum(frame_sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: p*0x10+p, mode 1: 0x010203
    task automatic load_pattern(input int mode);
        for (int i = 0; i < NP; i++) begin
            exp_pix[i] = (mode == 0) ? 24'(i * 16 + i) : 24'h010203;
            screen[24*i +: 24] = exp_pix[i];
        end
    endtask

    task automatic start_frame(input logic keep_en);
        enable = 1'b1;
        step();
        chk("cap_busy", busy, 1);
        chk("cap_valid", pix_valid, 0);
        enable = keep_en;
        step();
        chk("first_valid", pix_valid, 1);
    endtask

    // Walks one frame from the current sample point. stall_k: pixel held 5 cycles
    // with ready low; abort_k: pixel at which reset is pulled; poison: overwrite
    // screen after the first transfer.
    task automatic run_frame(input int stall_k, input int abort_k, input bit poison);
        int k = 0, gap = 0, guard = 0;
        while (k < NP && guard < 300) begin
            guard++;
            if (pix_valid) begin
                if (k > 0) chk("gap", gap, (k % W == 0) ? BH : 0);
                chk("px_x", pix_x, k % W);
                chk("px_y", pix_y, k / W);
                chk("px_rgb", pix_rgb, exp_pix[k]);
                chk("line_end", line_end, (k % W == W - 1));
                chk("frame_end", frame_end, (k == NP - 1));
                if (k == abort_k) begin
                    reset = 1'b0;
                    #1;
                    chk("rst_valid", pix_valid, 0);
                    chk("rst_rgb", pix_rgb, 0);
                    chk("rst_xy", {pix_x, pix_y}, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_le", line_end, 0);
                    return;
                end
                if (k == stall_k) begin
                    pix_ready = 1'b0;
                    repeat (5) begin
                        step();
                        chk("hold_valid", pix_valid, 1);
                        chk("hold_rgb", pix_rgb, exp_pix[k]);
                        chk("hold_xy", {pix_x, pix_y}, {2'(k % W), 2'(k / W)});
                        chk("hold_le", line_end, (k % W == W - 1));
                    end
                    pix_ready = 1'b1;
                end
                step();
                k++;
                gap = 0;
                if (poison && k == 1) screen = {NP{24'hFFFFFF}};
            end else begin
                step();
                gap++;
            end
        end
        if (k < NP) chk("frame_timeout", k, NP);
    endtask

    // Called at the sample right after the last transfer.
    task automatic after_frame(input bit restart);
        repeat (BV) begin
            chk("vb_valid", pix_valid, 0);
            chk("vb_busy", busy, 1);
            step();
        end
        chk("vb_exit_busy", busy, restart);
        chk("vb_exit_valid", pix_valid, 0);
    endtask

    initial begin
        logic [15:0] sum_p, sum_c;
`ifdef SCAN_CHECKSUM_EN
        sum_p = 16'd1122;
        sum_c = 16'd72;
`else
        sum_p = 16'd0;
        sum_c = 16'd0;
`endif
        reset     = 1'b0;
        enable    = 1'b0;
        pix_ready = 1'b1;
        load_pattern(0);
        repeat (3) step();
        chk("rst_valid0", pix_valid, 0);
        chk("rst_sum0", frame_sum, 0);
        reset = 1'b1;
        repeat (5) begin
            step();
            chk("idle_valid", pix_valid, 0);
            chk("idle_busy", busy, 0);
            chk("idle_xy", {pix_x, pix_y}, 0);
        end

        // Plain frame, ready held high
        start_frame(1'b0);
        run_frame(-1, -1, 1'b0);
        chk("sum_p", frame_sum, sum_p);
        after_frame(1'b0);
        step();
        chk("idle_after", busy, 0);

        // Backpressure at (2,1)
        start_frame(1'b0);
        run_frame(6, -1, 1'b0);
        after_frame(1'b0);

        // Snapshot isolation, enable held so the next frame recaptures
        start_frame(1'b1);
        run_frame(-1, -1, 1'b1);
        after_frame(1'b1);
        enable = 1'b0;
        for (int i = 0; i < NP; i++) exp_pix[i] = 24'hFFFFFF;
        step();
        chk("recap_valid", pix_valid, 1);
        run_frame(-1, -1, 1'b0);
        after_frame(1'b0);

        // Mid-frame reset at (1,1), then a 0x010203 frame from (0,0)
        load_pattern(0);
        start_frame(1'b0);
        run_frame(-1, 5, 1'b0);
        chk("abort_sum", frame_sum, 0);
        reset = 1'b1;
        load_pattern(1);
        start_frame(1'b0);
        run_frame(-1, -1, 1'b0);
        chk("sum_c", frame_sum, sum_c);
        after_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
